// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to the
// instruction memory and fills the IF/ID register for decode.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     PC_STEP   = 4,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            imem_valid_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc_next_o,
  output logic [31:0]     if_id_instr_o
);

  typedef enum logic [1:0] {ISSUE, WAIT, BUF, DROP} state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_buf;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_target;
  logic            accept;
  logic [31:0]     accept_word;

  assign pc_inc          = pc_q + XLEN'(PC_STEP);
  assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign imem_req_o      = (state == ISSUE);
  assign imem_addr_o     = pc_q;

  // A word reaches IF/ID only when neither a flush nor a stall blocks it;
  // in BUF the word comes from the stall buffer instead of the memory bus.
  always_comb begin
    accept      = 1'b0;
    accept_word = imem_rdata_i;
    if (!redirect_i && !stall_i) begin
      if (state == WAIT && imem_valid_i) begin
        accept = 1'b1;
      end else if (state == BUF) begin
        accept      = 1'b1;
        accept_word = instr_buf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ISSUE;
      pc_q            <= RESET_PC;
      instr_buf       <= NOP_INSTR;
      if_id_valid_o   <= 1'b0;
      if_id_pc_o      <= '0;
      if_id_pc_next_o <= '0;
      if_id_instr_o   <= NOP_INSTR;
    end else begin
      case (state)
        ISSUE: begin
          if (redirect_i) begin
            pc_q  <= redirect_target;
            state <= DROP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_valid_i && redirect_i) begin
            pc_q  <= redirect_target;
            state <= ISSUE;
          end else if (imem_valid_i && stall_i) begin
            instr_buf <= imem_rdata_i;
            state     <= BUF;
          end else if (imem_valid_i) begin
            pc_q  <= pc_inc;
            state <= ISSUE;
          end else if (redirect_i) begin
            pc_q  <= redirect_target;
            state <= DROP;
          end
        end
        BUF: begin
          if (redirect_i) begin
            pc_q  <= redirect_target;
            state <= ISSUE;
          end else if (!stall_i) begin
            pc_q  <= pc_inc;
            state <= ISSUE;
          end
        end
        DROP: begin
          // The stale response must drain before the new target is requested.
          if (redirect_i) pc_q <= redirect_target;
          if (imem_valid_i) state <= ISSUE;
        end
        default: state <= ISSUE;
      endcase

      if (redirect_i) begin
        if_id_valid_o <= 1'b0;
        if_id_instr_o <= NOP_INSTR;
      end else if (!stall_i) begin
        if (accept) begin
          if_id_valid_o   <= 1'b1;
          if_id_pc_o      <= pc_q;
          if_id_pc_next_o <= pc_inc;
          if_id_instr_o   <= accept_word;
        end else begin
          if_id_valid_o <= 1'b0;
          if_id_instr_o <= NOP_INSTR;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle-stepped memory model answers requests
// after a programmable latency; a second instance covers a high RESET_PC.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o, imem_valid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o, if_id_pc_next_o, if_id_instr_o;

  logic        stall5, redirect5;
  logic [31:0] redirect_pc5;
  logic        req5, valid5;
  logic [31:0] addr5, rdata5;
  logic        ifv5;
  logic [31:0] ifpc5, ifpcn5, ifinstr5;

  int          checks;
  int          failures;

  logic        mem_pend;
  int          mem_left;
  int          mem_lat;
  logic [31:0] mem_addr;
  logic [31:0] data_off;
  logic        mem5_pend;
  logic [31:0] mem5_addr;

  fetch_stage u_dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .imem_valid_i(imem_valid_i),
    .if_id_valid_o(if_id_valid_o), .if_id_pc_o(if_id_pc_o),
    .if_id_pc_next_o(if_id_pc_next_o), .if_id_instr_o(if_id_instr_o)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut5 (
    .clk(clk), .reset(reset), .stall_i(stall5), .redirect_i(redirect5),
    .redirect_pc_i(redirect_pc5), .imem_req_o(req5), .imem_addr_o(addr5),
    .imem_rdata_i(rdata5), .imem_valid_i(valid5),
    .if_id_valid_o(ifv5), .if_id_pc_o(ifpc5),
    .if_id_pc_next_o(ifpcn5), .if_id_instr_o(ifinstr5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, runs both memory models, then advances past
  // the next rising edge so outputs are sampled away from it.
  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc);
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem_valid_i  = 1'b0;
    valid5        = 1'b0;
    if (reset) begin
      mem_pend  = 1'b0;
      mem5_pend = 1'b0;
    end else begin
      if (mem_pend) begin
        mem_left--;
        if (mem_left == 0) begin
          imem_valid_i = 1'b1;
          imem_rdata_i = mem_addr + data_off;
          mem_pend     = 1'b0;
        end
      end
      if (imem_req_o) begin
        mem_pend = 1'b1;
        mem_left = mem_lat;
        mem_addr = imem_addr_o;
      end
      if (mem5_pend) begin
        valid5    = 1'b1;
        rdata5    = mem5_addr;
        mem5_pend = 1'b0;
      end
      if (req5) begin
        mem5_pend = 1'b1;
        mem5_addr = addr5;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_valid_i = 1'b0; imem_rdata_i = '0;
    stall5 = 1'b0; redirect5 = 1'b0; redirect_pc5 = '0;
    valid5 = 1'b0; rdata5 = '0;
    mem_pend = 1'b0; mem_left = 0; mem_lat = 1; mem_addr = '0; data_off = '0;
    mem5_pend = 1'b0; mem5_addr = '0;

    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("rst_req", 32'(imem_req_o), 32'd1);
    checkOutput("rst_addr", imem_addr_o, 32'h0);
    checkOutput("rst_valid", 32'(if_id_valid_o), 32'd0);
    checkOutput("rst_instr", if_id_instr_o, 32'h0);
    checkOutput("rst_pc", if_id_pc_o, 32'h0);
    checkOutput("rst_pcnext", if_id_pc_next_o, 32'h0);
    checkOutput("rst5_addr", addr5, 32'hFFFF_FFF8);
    reset = 1'b0;

    // T1: sequential fetch with a 1-cycle memory returning address as data
    applyStimulus(0, 0, 0);
    checkOutput("t1_req_wait", 32'(imem_req_o), 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("t1_v0", 32'(if_id_valid_o), 32'd1);
    checkOutput("t1_pc0", if_id_pc_o, 32'h0);
    checkOutput("t1_instr0", if_id_instr_o, 32'h0);
    checkOutput("t1_pcn0", if_id_pc_next_o, 32'h4);
    checkOutput("t1_addr4", imem_addr_o, 32'h4);
    checkOutput("t5_pc_fff8", ifpc5, 32'hFFFF_FFF8);
    checkOutput("t5_addr_fffc", addr5, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0);
    checkOutput("t1_bubble", 32'(if_id_valid_o), 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("t1_v4", 32'(if_id_valid_o), 32'd1);
    checkOutput("t1_pc4", if_id_pc_o, 32'h4);
    checkOutput("t1_instr4", if_id_instr_o, 32'h4);
    checkOutput("t1_addr8", imem_addr_o, 32'h8);
    checkOutput("t5_pc_fffc", ifpc5, 32'hFFFF_FFFC);
    checkOutput("t5_pcn_wrap", ifpcn5, 32'h0);
    checkOutput("t5_addr_wrap", addr5, 32'h0);
    checkOutput("t5_instr", ifinstr5, 32'hFFFF_FFFC);

    // T2: stall for three cycles while the word for pc 8 arrives
    data_off = 32'h1000_0000;
    applyStimulus(1, 0, 0);
    checkOutput("t2_hold_pc_a", if_id_pc_o, 32'h4);
    checkOutput("t2_noreq_a", 32'(imem_req_o), 32'd0);
    applyStimulus(1, 0, 0);
    checkOutput("t2_hold_v_b", 32'(if_id_valid_o), 32'd1);
    checkOutput("t2_noreq_b", 32'(imem_req_o), 32'd0);
    checkOutput("t5_pc0", ifpc5, 32'h0);
    applyStimulus(1, 0, 0);
    checkOutput("t2_hold_pc_c", if_id_pc_o, 32'h4);
    checkOutput("t2_hold_instr_c", if_id_instr_o, 32'h4);
    checkOutput("t2_noreq_c", 32'(imem_req_o), 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("t2_v8", 32'(if_id_valid_o), 32'd1);
    checkOutput("t2_pc8", if_id_pc_o, 32'h8);
    checkOutput("t2_instr8", if_id_instr_o, 32'h1000_0008);
    checkOutput("t2_pcn8", if_id_pc_next_o, 32'hC);
    checkOutput("t2_addrC", imem_addr_o, 32'hC);

    // T3: redirect while waiting on a 3-cycle memory
    mem_lat = 3;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 32'h100);
    checkOutput("t3_flush_v", 32'(if_id_valid_o), 32'd0);
    checkOutput("t3_noreq", 32'(imem_req_o), 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("t3_drop_noreq", 32'(imem_req_o), 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("t3_req", 32'(imem_req_o), 32'd1);
    checkOutput("t3_addr", imem_addr_o, 32'h100);
    checkOutput("t3_discard_v", 32'(if_id_valid_o), 32'd0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("t3_pending_v", 32'(if_id_valid_o), 32'd0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("t3_v100", 32'(if_id_valid_o), 32'd1);
    checkOutput("t3_pc100", if_id_pc_o, 32'h100);
    checkOutput("t3_instr100", if_id_instr_o, 32'h1000_0100);
    checkOutput("t3_addr104", imem_addr_o, 32'h104);

    // T4: redirect and stall together over a valid IF/ID, unaligned target
    mem_lat = 1;
    applyStimulus(1, 1, 32'h103);
    checkOutput("t4_flush_v", 32'(if_id_valid_o), 32'd0);
    checkOutput("t4_flush_instr", if_id_instr_o, 32'h0);
    applyStimulus(0, 0, 0);
    checkOutput("t4_req", 32'(imem_req_o), 32'd1);
    checkOutput("t4_addr_align", imem_addr_o, 32'h100);
    checkOutput("t4_drop_v", 32'(if_id_valid_o), 32'd0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("t4_pc100", if_id_pc_o, 32'h100);
    checkOutput("t4_instr100", if_id_instr_o, 32'h1000_0100);

    // Redirect coinciding with a response in WAIT, then redirect out of BUF
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 32'h40);
    checkOutput("wr_v", 32'(if_id_valid_o), 32'd0);
    checkOutput("wr_addr", imem_addr_o, 32'h40);
    checkOutput("wr_req", 32'(imem_req_o), 32'd1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 32'h80);
    checkOutput("br_v", 32'(if_id_valid_o), 32'd0);
    checkOutput("br_addr", imem_addr_o, 32'h80);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("br_pc80", if_id_pc_o, 32'h80);
    checkOutput("br_instr80", if_id_instr_o, 32'h1000_0080);
    checkOutput("br_pcn84", if_id_pc_next_o, 32'h84);

    // T6: reset while in WAIT, then while in BUF
    applyStimulus(0, 0, 0);
    reset = 1'b1;
    applyStimulus(0, 0, 0);
    reset = 1'b0;
    checkOutput("t6w_req", 32'(imem_req_o), 32'd1);
    checkOutput("t6w_addr", imem_addr_o, 32'h0);
    checkOutput("t6w_v", 32'(if_id_valid_o), 32'd0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    reset = 1'b1;
    applyStimulus(1, 0, 0);
    reset = 1'b0;
    checkOutput("t6b_req", 32'(imem_req_o), 32'd1);
    checkOutput("t6b_addr", imem_addr_o, 32'h0);
    checkOutput("t6b_v", 32'(if_id_valid_o), 32'd0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("t6_v0", 32'(if_id_valid_o), 32'd1);
    checkOutput("t6_instr0", if_id_instr_o, 32'h1000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
